// File: rtl/sdram_block_copier_pkg.sv
// Shared encodings for the SDRAM block copier: transform modes and FSM states.
package sdram_copier_pkg;

  typedef enum logic [1:0] {
    MODE_COPY = 2'd0,
    MODE_ADD  = 2'd1,
    MODE_XOR  = 2'd2,
    MODE_FILL = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRdWait,
    StWr,
    StDone
  } state_e;

endpackage

// File: rtl/sdram_block_copier_if.sv
// Avalon-MM master/slave bundle between the copier and the SDRAM controller.
interface sdram_block_copier_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 32
) ();

  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                read_n;
  logic                write_n;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic                readdatavalid;
  logic [DATA_W-1:0]   readdata;

  modport master (
    output address, chipselect, read_n, write_n, byteenable, writedata,
    input  waitrequest, readdatavalid, readdata
  );

  modport slave (
    input  address, chipselect, read_n, write_n, byteenable, writedata,
    output waitrequest, readdatavalid, readdata
  );

endinterface

// File: rtl/sdram_block_copier_fifo.sv
// Synchronous read-data FIFO; pointers carry one extra wrap bit so full and empty differ.
module sdram_copy_fifo #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [DATA_W-1:0]            wdata_i,
  output logic [DATA_W-1:0]            rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(FIFO_DEPTH):0]  count_o
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW = AW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count_o == PtrW'(FIFO_DEPTH));
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/sdram_block_copier.sv
// Avalon-MM block copier: batched pipelined reads into a FIFO, then transformed writes.
module sdram_block_copier
  import sdram_copier_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [ADDR_W-1:0] src_base_i,
  input  logic [ADDR_W-1:0] dst_base_i,
  input  logic [LEN_W-1:0]  length_i,
  input  logic [DATA_W-1:0] operand_i,
  output logic              busy_o,
  output logic              done_o,
  sdram_block_copier_if.master avm
);

  localparam int unsigned BeW  = DATA_W / 8;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic [CntW-1:0]   batch_q, batch_d;

  logic              rd_req, wr_req, rd_ok, fifo_push, fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [CntW-1:0]   fifo_count;
  logic [DATA_W-1:0] fifo_head, wdata;
  logic [ADDR_W-1:0] rd_addr, wr_addr;

  // Read data is only accepted while a batch is in flight; stale returns are dropped.
  assign fifo_push = avm.readdatavalid && ((state_q == StRd) || (state_q == StRdWait));

  sdram_copy_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (avm.readdata),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign rd_addr = src_q + ADDR_W'(rd_cnt_q) * ADDR_W'(BeW);
  assign wr_addr = dst_q + ADDR_W'(wr_cnt_q) * ADDR_W'(BeW);
  assign rd_ok   = (batch_q < CntW'(FIFO_DEPTH)) && (rd_cnt_q < len_q);

  always_comb begin
    case (mode_q)
      MODE_ADD: wdata = fifo_head + op_q;
      MODE_XOR: wdata = fifo_head ^ op_q;
      MODE_FILL: wdata = op_q;
      default:  wdata = fifo_head;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    op_d     = op_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    batch_d  = batch_q;
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    fifo_pop = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mode_d   = mode_e'(mode_i);
          src_d    = src_base_i;
          dst_d    = dst_base_i;
          len_d    = length_i;
          op_d     = operand_i;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          batch_d  = '0;
          if (length_i == '0)            state_d = StDone;
          else if (mode_i == MODE_FILL)  state_d = StWr;
          else                           state_d = StRd;
        end
      end
      StRd: begin
        if (rd_ok) begin
          rd_req = 1'b1;
          if (!avm.waitrequest) begin
            rd_cnt_d = rd_cnt_q + LEN_W'(1);
            batch_d  = batch_q + CntW'(1);
            if ((batch_q + CntW'(1) == CntW'(FIFO_DEPTH)) || (rd_cnt_q + LEN_W'(1) == len_q))
              state_d = StRdWait;
          end
        end else begin
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (fifo_count == batch_q) begin
          batch_d = '0;
          state_d = StWr;
        end
      end
      StWr: begin
        if (mode_q == MODE_FILL) begin
          wr_req = 1'b1;
          if (!avm.waitrequest) begin
            wr_cnt_d = wr_cnt_q + LEN_W'(1);
            batch_d  = (batch_q + CntW'(1) == CntW'(FIFO_DEPTH)) ? '0 : batch_q + CntW'(1);
            if (wr_cnt_q + LEN_W'(1) == len_q) state_d = StDone;
          end
        end else if (!fifo_empty) begin
          wr_req = 1'b1;
          if (!avm.waitrequest) begin
            fifo_pop = 1'b1;
            wr_cnt_d = wr_cnt_q + LEN_W'(1);
            if (fifo_count == CntW'(1))
              state_d = (wr_cnt_q + LEN_W'(1) == len_q) ? StDone : StRd;
          end
        end else begin
          state_d = (wr_cnt_q == len_q) ? StDone : StRd;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      mode_q   <= MODE_COPY;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      op_q     <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      batch_q  <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      op_q     <= op_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      batch_q  <= batch_d;
    end
  end

  assign avm.read_n     = !rd_req;
  assign avm.write_n    = !wr_req;
  assign avm.chipselect = rd_req || wr_req;
  assign avm.byteenable = (rd_req || wr_req) ? '1 : '0;
  assign avm.address    = rd_req ? rd_addr : (wr_req ? wr_addr : '0);
  assign avm.writedata  = wr_req ? wdata : '0;
  assign busy_o         = (state_q == StRd) || (state_q == StRdWait) || (state_q == StWr);
  assign done_o         = (state_q == StDone);

endmodule

// File: tb/tb_sdram_block_copier.sv
// Directed bench for sdram_block_copier with an Avalon slave/memory model and scoreboard.
module tb_sdram_block_copier;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] src = '0, dst = '0;
  logic [15:0] len = '0, op = '0;
  logic        busy, done;

  sdram_block_copier_if #(.DATA_W(16), .ADDR_W(32)) bus ();

  sdram_block_copier #(
    .DATA_W     (16),
    .ADDR_W     (32),
    .LEN_W      (16),
    .FIFO_DEPTH (8)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .start_i    (start),
    .mode_i     (mode),
    .src_base_i (src),
    .dst_base_i (dst),
    .length_i   (len),
    .operand_i  (op),
    .busy_o     (busy),
    .done_o     (done),
    .avm        (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [15:0] mem [0:1023];
  logic [31:0] exp_ra[$], exp_wa[$], wlog_a[$];
  logic [15:0] exp_wd[$], wlog_d[$];
  int          batch_log[$];
  int          rq_due[$], rq_ep[$];
  logic [15:0] rq_dat[$];
  int cyc = 0, last_due = 0, epoch = 0, outstanding = 0;
  int rd_run = 0, done_cnt = 0, rdn_cycles = 0;
  int lat_lo = 1, lat_hi = 1;
  bit stall_en = 1'b0;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_cmd;

  function automatic logic [15:0] model_word(input logic [1:0] m, input logic [15:0] d,
                                             input logic [15:0] o);
    case (m)
      2'd0:    return d;
      2'd1:    return d + o;
      2'd2:    return d ^ o;
      default: return o;
    endcase
  endfunction

  // Slave model: drive stalls/returns at negedge, sample the settled bus 1ns later.
  always @(negedge clk) begin
    cyc++;
    if (rq_due.size() != 0 && rq_due[0] <= cyc) begin
      bus.readdatavalid = 1'b1;
      bus.readdata      = rq_dat[0];
      if (rq_ep[0] == epoch && outstanding > 0) outstanding--;
      void'(rq_due.pop_front());
      void'(rq_dat.pop_front());
      void'(rq_ep.pop_front());
    end else begin
      bus.readdatavalid = 1'b0;
      bus.readdata      = 16'($urandom);
    end
    bus.waitrequest = stall_en && ($urandom_range(0, 2) == 0);
    #1;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (!bus.read_n || !bus.write_n) begin
        chk("rw_exclusive", bus.read_n | bus.write_n, 1'b1);
        chk("cs_be_on_cmd", {bus.chipselect, bus.byteenable}, 3'b111);
      end
      if (prev_stall)
        chk("hold_during_stall", {bus.address, bus.read_n, bus.write_n, bus.writedata}, prev_cmd);
      prev_stall = bus.chipselect && bus.waitrequest;
      prev_cmd   = {bus.address, bus.read_n, bus.write_n, bus.writedata};
      if (!bus.read_n) rdn_cycles++;
      if (done) done_cnt++;
      if (bus.chipselect && !bus.read_n && !bus.waitrequest) begin
        int due;
        if (exp_ra.size() != 0) chk("rd_addr", bus.address, exp_ra.pop_front());
        else chk("rd_unexpected", bus.address, 64'hDEAD_BEEF_DEAD_BEEF);
        outstanding++;
        rd_run++;
        chk("outstanding_le_8", outstanding <= 8, 1'b1);
        due = cyc + int'($urandom_range(lat_lo, lat_hi));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        rq_due.push_back(due);
        rq_dat.push_back(mem[bus.address[10:1]]);
        rq_ep.push_back(epoch);
      end
      if (bus.chipselect && !bus.write_n && !bus.waitrequest) begin
        if (exp_wa.size() != 0) begin
          chk("wr_addr", bus.address, exp_wa.pop_front());
          chk("wr_data", bus.writedata, exp_wd.pop_front());
        end else begin
          chk("wr_unexpected", bus.address, 64'hDEAD_BEEF_DEAD_BEEF);
        end
        wlog_a.push_back(bus.address);
        wlog_d.push_back(bus.writedata);
        if (rd_run > 0) begin
          batch_log.push_back(rd_run);
          rd_run = 0;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    chk(name, {bus.address, bus.writedata, bus.byteenable, bus.read_n, bus.write_n,
               bus.chipselect, busy, done}, {32'h0, 16'h0, 2'b00, 5'b11000});
  endtask

  task automatic setup_expect(input logic [1:0] m, input logic [31:0] s, input logic [31:0] d,
                              input logic [15:0] l, input logic [15:0] o);
    exp_ra.delete(); exp_wa.delete(); exp_wd.delete();
    wlog_a.delete(); wlog_d.delete(); batch_log.delete();
    rd_run = 0;
    for (int i = 0; i < int'(l); i++) begin
      logic [31:0] sa;
      sa = s + 32'(2 * i);
      if (m != 2'd3) exp_ra.push_back(sa);
      exp_wa.push_back(d + 32'(2 * i));
      exp_wd.push_back(model_word(m, mem[sa[10:1]], o));
    end
  endtask

  task automatic run_xfer(input logic [1:0] m, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] l, input logic [15:0] o, input bit poke);
    int d0, r0;
    setup_expect(m, s, d, l, o);
    d0 = done_cnt;
    r0 = rdn_cycles;
    @(negedge clk);
    mode = m; src = s; dst = d; len = l; op = o; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = ~m; src = ~s; dst = ~d; len = 16'd7; op = ~o;
    #2;
    if (l == 16'd0) begin
      chk("zero_len_done_pulse", {done, busy, bus.chipselect}, 3'b100);
    end else begin
      chk("busy_after_start", busy, 1'b1);
      if (m == 2'd3) chk("first_cmd_write", {bus.write_n, bus.address}, {1'b0, d});
      else           chk("first_cmd_read", {bus.read_n, bus.address}, {1'b0, s});
    end
    if (poke) begin
      repeat (2) @(negedge clk);
      #2;
      chk("busy_at_poke", busy, 1'b1);
      mode = 2'd0; src = 32'h300; dst = 32'h380; len = 16'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int k = 0; k < 3000 && done_cnt == d0; k++) begin
      @(negedge clk);
      #2;
    end
    if (done_cnt == d0) chk("done_timeout", 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    #2;
    chk("done_once", done_cnt - d0, 1);
    chk("writes_outstanding", exp_wa.size(), 0);
    chk("reads_outstanding", exp_ra.size(), 0);
    chk("idle_after_done", {busy, done}, 2'b00);
    if (rd_run > 0) begin
      batch_log.push_back(rd_run);
      rd_run = 0;
    end
    if (m == 2'd3) chk("fill_no_read", rdn_cycles - r0, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 37 + 5);
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
    mem[16] = 16'hFFFF; mem[17] = 16'h0004;
    mem[24] = 16'h1234;

    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs("reset_values");
    reset = 1'b0;

    run_xfer(2'd0, 32'h0, 32'h100, 16'd3, 16'h0, 1'b0);
    chk("copy_addr0", wlog_a[0], 32'h100);
    chk("copy_addr2", wlog_a[2], 32'h104);
    chk("copy_data", {wlog_d[0], wlog_d[1], wlog_d[2]}, 48'h1111_2222_3333);

    run_xfer(2'd1, 32'h20, 32'h140, 16'd2, 16'h0001, 1'b0);
    chk("add_wrap", {wlog_d[0], wlog_d[1]}, 32'h0000_0005);

    stall_en = 1'b1; lat_lo = 1; lat_hi = 5;
    run_xfer(2'd0, 32'h200, 32'h600, 16'd20, 16'h0, 1'b0);
    chk("batch_count", batch_log.size(), 3);
    chk("batch_sizes", {8'(batch_log[0]), 8'(batch_log[1]), 8'(batch_log[2])}, 24'h08_08_04);
    chk("long_write_count", wlog_a.size(), 20);

    run_xfer(2'd3, 32'h0, 32'h700, 16'd10, 16'hA5A5, 1'b0);
    chk("fill_count", wlog_d.size(), 10);
    chk("fill_last", {wlog_a[9], wlog_d[9]}, {32'h712, 16'hA5A5});
    stall_en = 1'b0;

    run_xfer(2'd0, 32'h0, 32'h100, 16'd0, 16'h0, 1'b0);
    chk("zero_len_no_traffic", wlog_a.size(), 0);

    // Reset while a batch of three reads is still in flight.
    lat_lo = 5; lat_hi = 5;
    setup_expect(2'd0, 32'h80, 32'h180, 16'd3, 16'h0);
    @(negedge clk);
    mode = 2'd0; src = 32'h80; dst = 32'h180; len = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
    for (int k = 0; k < 50 && !(outstanding == 3 && bus.read_n); k++) begin
      @(negedge clk);
      #2;
    end
    chk("reached_rd_wait", {outstanding == 3, bus.read_n, busy}, 3'b111);
    @(negedge clk);
    reset = 1'b1;
    epoch++;
    outstanding = 0;
    exp_ra.delete(); exp_wa.delete(); exp_wd.delete(); wlog_a.delete();
    @(negedge clk);
    #2;
    check_reset_outputs("reset_mid_transfer");
    reset = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    chk("late_data_ignored", {wlog_a.size(), busy}, {32'd0, 1'b0});
    chk("late_data_drained", rq_due.size(), 0);
    lat_lo = 1; lat_hi = 2;
    run_xfer(2'd0, 32'h80, 32'h180, 16'd3, 16'h0, 1'b0);

    lat_lo = 3; lat_hi = 3;
    run_xfer(2'd2, 32'h30, 32'h1C0, 16'd1, 16'h00FF, 1'b1);
    chk("xor_value", {wlog_a.size(), wlog_d[0]}, {32'd1, 16'h12CB});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
